camera_pixel_feeder: RTL and testbench
======================================

Name: camera_pixel_feeder

Overview:
Producer end of the camera-to-VGA pixel interface. It accepts a raw RGB pixel stream from the camera capture logic and assigns each pixel a screen x/y coordinate. Pixels are converted to 15-bit colour and buffered in a show-ahead FIFO. The FIFO head is presented to the VGA controller on camera_to_vga_valid/x/y/color and is popped by the VGA's single-cycle camera_to_vga_ack.

Parameters:
FRAME_WIDTH, 640, pixels per line; x wraps from FRAME_WIDTH-1 to 0.
FRAME_HEIGHT, 480, lines per frame; y wraps from FRAME_HEIGHT-1 to 0.
FIFO_DEPTH, 16, FIFO entries; must be a power of 2.
FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
clock_100m  in  1  system clock
reset_100m  in  1  asynchronous, active-high reset
capture_enable  in  1  when 0, incoming pixels are ignored
pixel_in_valid  in  1  one-cycle strobe: pixel_in_r/g/b hold a pixel
pixel_in_sof  in  1  qualifies pixel_in_valid: this pixel is (0,0) of a new frame
pixel_in_r  in  8  red
pixel_in_g  in  8  green
pixel_in_b  in  8  blue
camera_to_vga_valid  out  1  FIFO non-empty
camera_to_vga_ack  in  1  one-cycle pop from VGA
camera_to_vga_x  out  10  head pixel x
camera_to_vga_y  out  10  head pixel y
camera_to_vga_color  out  15  head colour {R[14:10],G[9:5],B[4:0]}
fifo_overflow  out  1  sticky: a pixel was dropped because the FIFO was full
dropped_count  out  16  saturating count of dropped pixels

Behaviour:
- Reset (async, reset_100m=1): write/read pointers, count, x/y counters, fifo_overflow and dropped_count go to 0. camera_to_vga_valid=0. Head outputs read 0, because the storage array is reset to 0.
- Accept: a pixel is accepted when pixel_in_valid=1 and capture_enable=1.
- Colour conversion on accept: colour = {r[7:3], g[7:3], b[7:3]}.
- Coordinate assignment on accept:
  - If pixel_in_sof=1, the pixel gets (0,0) and the counters become x=1, y=0.
  - Otherwise the pixel gets the current (x,y), then the counters advance.
  - Advance rule: if x==FRAME_WIDTH-1, x goes to 0 and y advances; otherwise x+1.
  - y wraps from FRAME_HEIGHT-1 to 0.
- Counters advance even when the pixel is dropped, so later pixels keep correct coordinates.
- Push: an accepted pixel is written into the FIFO (35-bit entry {y,x,color}) unless the FIFO is full and camera_to_vga_ack=0 in the same cycle.
- Drop on full:
  - fifo_overflow sets to 1 and holds until reset.
  - dropped_count increments and saturates at 16'hFFFF.
- Full with simultaneous pop: if the FIFO is full and ack=1 in the same cycle, the push is accepted; count stays FIFO_DEPTH.
- Pop: on camera_to_vga_ack=1 with count>0, read pointer +1 and count -1.
  - ack while empty is ignored: no pointer change, no error.
  - Simultaneous push and pop on a non-empty FIFO leaves count unchanged.
- Show-ahead head:
  - camera_to_vga_x/y/color are driven combinationally from the entry at the read pointer.
  - They must stay stable from when valid rises until the cycle after ack, so the VGA may sample them on any cycle before its ack.
  - Head data changes only on a pop.
- camera_to_vga_valid is registered as (next count != 0):
  - It rises 1 cycle after the first push into an empty FIFO.
  - It falls in the cycle after the pop of the last entry.
  - A push into an empty FIFO is therefore visible 1 cycle later; no combinational path from pixel_in to outputs.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH and uses FIFO_AW+1 bits.
- capture_enable=0 holds the x/y counters; FIFO drain continues normally.
- No reset mid-frame recovery: after reset, coordinates restart at (0,0), and pixel_in_sof resynchronises.

Test Plan:
- Reset, then 3 accepted pixels (sof on the first, r=8'hFF g=0 b=8'h08) with no ack -> valid=1 from cycle 2; head x=0 y=0 color=15'h7C01; count=3.
- Stream 641 pixels starting with sof while acking every entry -> pixel 640 is popped with x=0 y=1; pixel 639 is popped with x=639 y=0.
- Push 17 pixels with no ack and FIFO_DEPTH=16 -> the 17th is dropped; fifo_overflow=1; dropped_count=1; the 16 entries drain in order with correct coordinates; the next pixel is accepted at the coordinate after the dropped one.
- FIFO full, push and ack in the same cycle -> push accepted; count stays 16; valid stays 1; head advances by one entry.
- Ack pulse while empty -> no change to pointers, valid or counters; a subsequent single push yields valid=1 one cycle later.
- Assert reset_100m asynchronously mid-stream with 5 entries buffered -> valid=0 immediately; count=0; next sof pixel appears at (0,0).

Source files
------------

// File: rtl/camera_pixel_feeder.sv
// rtl/camera_pixel_feeder.sv - camera pixel stream to VGA feeder with x/y tagging and show-ahead FIFO
module camera_pixel_feeder #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic        clock_100m,
  input  logic        reset_100m,
  input  logic        capture_enable,
  input  logic        pixel_in_valid,
  input  logic        pixel_in_sof,
  input  logic [7:0]  pixel_in_r,
  input  logic [7:0]  pixel_in_g,
  input  logic [7:0]  pixel_in_b,
  output logic        camera_to_vga_valid,
  input  logic        camera_to_vga_ack,
  output logic [9:0]  camera_to_vga_x,
  output logic [9:0]  camera_to_vga_y,
  output logic [14:0] camera_to_vga_color,
  output logic        fifo_overflow,
  output logic [15:0] dropped_count
);

  localparam logic [9:0]       X_LAST    = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0]       Y_LAST    = 10'(FRAME_HEIGHT - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [34:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic [9:0]         x_cnt;
  logic [9:0]         y_cnt;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [9:0]         x_next;
  logic [9:0]         y_next;
  logic [14:0]        pix_color;
  logic               accept;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;
  logic               unused_low_bits;

  assign accept    = pixel_in_valid & capture_enable;
  assign full      = (count == DEPTH_CNT);
  assign pop       = camera_to_vga_ack & (count != '0);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push      = accept & (~full | camera_to_vga_ack);
  assign drop      = accept & ~push;
  assign pix_color = {pixel_in_r[7:3], pixel_in_g[7:3], pixel_in_b[7:3]};
  assign unused_low_bits = ^{pixel_in_r[2:0], pixel_in_g[2:0], pixel_in_b[2:0]};

  // Start-of-frame forces (0,0), so the same advance rule yields x=1, y=0.
  always_comb begin
    pix_x  = pixel_in_sof ? '0 : x_cnt;
    pix_y  = pixel_in_sof ? '0 : y_cnt;
    x_next = pix_x + 10'd1;
    y_next = pix_y;
    if (pix_x == X_LAST) begin
      x_next = '0;
      y_next = (pix_y == Y_LAST) ? '0 : pix_y + 10'd1;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock_100m or posedge reset_100m) begin
    if (reset_100m) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {pix_y, pix_x, pix_color};
    end
  end

  always_ff @(posedge clock_100m or posedge reset_100m) begin
    if (reset_100m) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      x_cnt               <= '0;
      y_cnt               <= '0;
      camera_to_vga_valid <= 1'b0;
      fifo_overflow       <= 1'b0;
      dropped_count       <= '0;
    end else begin
      count               <= count_next;
      camera_to_vga_valid <= (count_next != '0);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Counters advance on every accepted pixel, dropped or not.
      if (accept) begin
        x_cnt <= x_next;
        y_cnt <= y_next;
      end
      if (drop) begin
        fifo_overflow <= 1'b1;
        if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      end
    end
  end

  assign {camera_to_vga_y, camera_to_vga_x, camera_to_vga_color} = mem[rd_ptr];

endmodule

// File: tb/tb_camera_pixel_feeder.sv
// tb/tb_camera_pixel_feeder.sv - directed self-checking bench for camera_pixel_feeder
module tb_camera_pixel_feeder;

  logic        clock_100m = 1'b0;
  logic        reset_100m = 1'b1;
  logic        capture_enable = 1'b1;
  logic        pixel_in_valid = 1'b0;
  logic        pixel_in_sof = 1'b0;
  logic [7:0]  pixel_in_r = '0;
  logic [7:0]  pixel_in_g = '0;
  logic [7:0]  pixel_in_b = '0;
  logic        camera_to_vga_ack = 1'b0;
  logic        camera_to_vga_valid;
  logic [9:0]  camera_to_vga_x;
  logic [9:0]  camera_to_vga_y;
  logic [14:0] camera_to_vga_color;
  logic        fifo_overflow;
  logic [15:0] dropped_count;

  int total = 0;
  int bad   = 0;

  camera_pixel_feeder dut (
    .clock_100m          (clock_100m),
    .reset_100m          (reset_100m),
    .capture_enable      (capture_enable),
    .pixel_in_valid      (pixel_in_valid),
    .pixel_in_sof        (pixel_in_sof),
    .pixel_in_r          (pixel_in_r),
    .pixel_in_g          (pixel_in_g),
    .pixel_in_b          (pixel_in_b),
    .camera_to_vga_valid (camera_to_vga_valid),
    .camera_to_vga_ack   (camera_to_vga_ack),
    .camera_to_vga_x     (camera_to_vga_x),
    .camera_to_vga_y     (camera_to_vga_y),
    .camera_to_vga_color (camera_to_vga_color),
    .fifo_overflow       (fifo_overflow),
    .dropped_count       (dropped_count)
  );

  always #5 clock_100m = ~clock_100m;

  typedef struct {
    logic        pv, sof, en, ack;
    logic [7:0]  r, g, b;
    logic        ev;
    logic [9:0]  ex, ey;
    logic [14:0] ec;
  } vec_t;

  vec_t tv[13];

  function automatic vec_t mk(input logic pv, input logic sof, input logic en, input logic ack,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic ev, input logic [9:0] ex, input logic [9:0] ey,
                              input logic [14:0] ec);
    vec_t v;
    v.pv = pv; v.sof = sof; v.en = en; v.ack = ack;
    v.r = r; v.g = g; v.b = b;
    v.ev = ev; v.ex = ex; v.ey = ey; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic a,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    pixel_in_valid = v; pixel_in_sof = s; capture_enable = e; camera_to_vga_ack = a;
    pixel_in_r = rr; pixel_in_g = gg; pixel_in_b = bb;
  endtask

  task automatic tick;
    @(posedge clock_100m);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    reset_100m = 1'b1;
    repeat (2) @(posedge clock_100m);
    #1 reset_100m = 1'b0;
  endtask

  // Pops the head after checking it against the expected entry.
  task automatic pop_check(input string nm, input int ex, input int ey, input logic [14:0] ec);
    check({nm, "_valid"}, 32'(camera_to_vga_valid), 32'd1);
    check({nm, "_xy"}, {12'd0, camera_to_vga_y, camera_to_vga_x}, {12'd0, 10'(ey), 10'(ex)});
    check({nm, "_color"}, 32'(camera_to_vga_color), 32'(ec));
    drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    tick;
    camera_to_vga_ack = 1'b0;
  endtask

  function automatic logic [14:0] stream_color(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v[7:3], v[10:6], ~v[7:3]};
  endfunction

  initial begin
    int popped;
    logic [31:0] iv;

    tv[0]  = mk(1, 1, 1, 0, 8'hFF, 8'h00, 8'h08, 1, 10'd0, 10'd0, 15'h7C01);
    tv[1]  = mk(1, 0, 1, 0, 8'h00, 8'hFF, 8'h00, 1, 10'd0, 10'd0, 15'h7C01);
    tv[2]  = mk(1, 0, 1, 0, 8'h00, 8'h00, 8'hFF, 1, 10'd0, 10'd0, 15'h7C01);
    tv[3]  = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 10'd1, 10'd0, 15'h03E0);
    tv[4]  = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 10'd2, 10'd0, 15'h001F);
    tv[5]  = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 10'd0, 10'd0, 15'h0000);
    tv[6]  = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 10'd0, 10'd0, 15'h0000);
    tv[7]  = mk(1, 0, 1, 0, 8'h08, 8'h08, 8'h08, 1, 10'd3, 10'd0, 15'h0421);
    tv[8]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 1, 10'd3, 10'd0, 15'h0421);
    tv[9]  = mk(1, 0, 0, 0, 8'h55, 8'h55, 8'h55, 1, 10'd3, 10'd0, 15'h0421);
    tv[10] = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 10'd0, 10'd0, 15'h0000);
    tv[11] = mk(1, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1, 10'd4, 10'd0, 15'h7FFF);
    tv[12] = mk(0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 10'd0, 10'd0, 15'h0000);

    do_reset;
    check("rst_valid", 32'(camera_to_vga_valid), 32'd0);
    check("rst_head", {camera_to_vga_y, camera_to_vga_x, camera_to_vga_color}, 32'd0);
    check("rst_ovf", 32'(fifo_overflow), 32'd0);
    check("rst_dropped", 32'(dropped_count), 32'd0);

    // Per-cycle vectors: basic push, colour, ack-while-empty, capture_enable hold.
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].pv, tv[i].sof, tv[i].en, tv[i].ack, tv[i].r, tv[i].g, tv[i].b);
      tick;
      check($sformatf("vec%0d_valid", i), 32'(camera_to_vga_valid), 32'(tv[i].ev));
      check($sformatf("vec%0d_xy", i), {12'd0, camera_to_vga_y, camera_to_vga_x},
            {12'd0, tv[i].ey, tv[i].ex});
      check($sformatf("vec%0d_color", i), 32'(camera_to_vga_color), 32'(tv[i].ec));
      check($sformatf("vec%0d_drop", i), {15'd0, fifo_overflow, dropped_count}, 32'd0);
    end

    // Line wrap: 641 pixels streamed with ack held high.
    do_reset;
    popped = 0;
    for (int i = 0; i < 646; i++) begin
      iv = 32'(i);
      if (i < 641) drive(1, i == 0, 1, 1, iv[7:0], iv[10:3], ~iv[7:0]);
      else         drive(0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
      if (camera_to_vga_valid) begin
        check($sformatf("stream%0d_xy", popped), {12'd0, camera_to_vga_y, camera_to_vga_x},
              {12'd0, 10'(popped / 640), 10'(popped % 640)});
        if (popped == 639 || popped == 640)
          check($sformatf("stream%0d_color", popped), 32'(camera_to_vga_color),
                32'(stream_color(popped)));
        popped++;
      end
      tick;
    end
    check("stream_pop_total", 32'(popped), 32'd641);
    check("stream_empty", 32'(camera_to_vga_valid), 32'd0);
    camera_to_vga_ack = 1'b0;

    // Overflow, full push+pop, ordered drain.
    do_reset;
    for (int i = 0; i < 17; i++) begin
      iv = 32'(i);
      drive(1, i == 0, 1, 0, {iv[4:0], 3'b000}, 8'h00, 8'h00);
      tick;
      if (i == 15) check("full_no_ovf", {15'd0, fifo_overflow, dropped_count}, 32'd0);
    end
    check("ovf_flag", 32'(fifo_overflow), 32'd1);
    check("ovf_dropped", 32'(dropped_count), 32'd1);
    check("ovf_head_x", 32'(camera_to_vga_x), 32'd0);
    drive(1, 0, 1, 1, {5'd17, 3'b000}, 8'h00, 8'h00);
    tick;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("fullpp_valid", 32'(camera_to_vga_valid), 32'd1);
    check("fullpp_head_x", 32'(camera_to_vga_x), 32'd1);
    check("fullpp_dropped", 32'(dropped_count), 32'd1);
    for (int k = 0; k < 16; k++) begin
      int ex;
      ex = (k < 15) ? k + 1 : 17;
      pop_check($sformatf("drain%0d", k), ex, 0, {5'(ex), 10'd0});
    end
    check("drain_empty", 32'(camera_to_vga_valid), 32'd0);
    drive(1, 0, 1, 0, {5'd18, 3'b000}, 8'h00, 8'h00);
    tick;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    pop_check("after_drop", 18, 0, {5'd18, 10'd0});
    check("ovf_sticky", 32'(fifo_overflow), 32'd1);

    // Asynchronous reset with 5 entries buffered.
    do_reset;
    for (int i = 0; i < 5; i++) begin
      drive(1, i == 0, 1, 0, 8'h80, 8'h80, 8'h80);
      tick;
    end
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    check("pre_arst_valid", 32'(camera_to_vga_valid), 32'd1);
    #3 reset_100m = 1'b1;
    #1;
    check("arst_valid", 32'(camera_to_vga_valid), 32'd0);
    check("arst_head", {camera_to_vga_y, camera_to_vga_x, camera_to_vga_color}, 32'd0);
    tick;
    reset_100m = 1'b0;
    tick;
    check("arst_hold_valid", 32'(camera_to_vga_valid), 32'd0);
    drive(1, 0, 1, 0, 8'h08, 8'h00, 8'h00);
    tick;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    pop_check("arst_first", 0, 0, 15'h0400);
    drive(1, 1, 1, 0, 8'h00, 8'h10, 8'h00);
    tick;
    drive(1, 0, 1, 0, 8'h00, 8'h00, 8'h18);
    tick;
    drive(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    pop_check("arst_sof", 0, 0, 15'h0040);
    pop_check("arst_next", 1, 0, 15'h0003);
    check("arst_end_empty", 32'(camera_to_vga_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
